// File: rtl/spi_slave_if.sv
// Purpose : mode-0 SPI slave front-end; synchronizes SCLK/CS/MOSI into CLK, deserializes
//           MSB-first words to rx_data and serializes tx_data words onto MISO.
// Latency : pin edge seen SYNC_STAGES+1 CLK edges later; rx_valid one CLK after the
//           detect cycle of the final SCLK rise; MISO updates one CLK after a detected fall.
// Backpr. : none; the SPI master sets the pace and upstream must keep up with tx_req.
//
// Ports:
//   CLK, RST     system clock and synchronous active-high reset
//   SCLK/CS/MOSI asynchronous SPI pins from the pad registers (CS active-low)
//   MISO         registered serial data out, 0 outside a frame
//   rx_data      last complete received word, qualified by the rx_valid pulse
//   tx_data      next word to send, latched when tx_req pulses
//   frame_*      frame_active level, frame_start/frame_end pulses
//   partial_err  pulse when a frame ends in the middle of a word
//   word_cnt     saturating count of words received in the current frame
module spi_slave_if #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 8,
  parameter int CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SCLK,
  input  logic              CS,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_req,
  output logic              frame_active,
  output logic              frame_start,
  output logic              frame_end,
  output logic              partial_err,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int BC_W   = $clog2(DATA_W);
  localparam int SETTLE = SYNC_STAGES + 1;
  localparam int ST_W   = $clog2(SETTLE + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Synchronizers: bit 0 is the first stage, bit SYNC_STAGES-1 the usable output.
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  // A CS fall only opens a frame once CS has been seen high after reset;
  // the settle counter lets the synchronizer flush its idle reset value first.
  logic [ST_W-1:0]        settle_cnt;
  logic                   armed;

  logic                   start_evt, end_evt, rise_evt, fall_evt;

  logic [BC_W-1:0]        bit_cnt;
  logic [DATA_W-2:0]      rx_shift;   // bits received so far in the current word
  logic [DATA_W-1:0]      rx_next;
  logic [DATA_W-1:0]      tx_shift;
  logic                   word_seen;  // at least one word completed in this frame

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sclk_rise =  sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s &  sclk_d;
  assign cs_fall   = ~cs_s   &  cs_d;
  assign cs_rise   =  cs_s   & ~cs_d;

  assign rx_next = {rx_shift, mosi_s};

  // MISO is the shifter MSB; the shifter is cleared whenever a frame ends,
  // which keeps MISO low outside a frame.
  assign MISO         = tx_shift[DATA_W-1];
  assign frame_active = (state_q == ACTIVE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      settle_cnt <= '0;
      armed      <= 1'b0;
    end else begin
      if (settle_cnt != ST_W'(SETTLE)) begin
        settle_cnt <= settle_cnt + ST_W'(1);
      end else if (cs_s && cs_d) begin
        armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // CS events take priority over SCLK edges detected in the same cycle.
  always_comb begin
    state_d   = state_q;
    start_evt = 1'b0;
    end_evt   = 1'b0;
    rise_evt  = 1'b0;
    fall_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall && armed) begin
          state_d   = ACTIVE;
          start_evt = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          end_evt = 1'b1;
        end else if (sclk_rise) begin
          rise_evt = 1'b1;
        end else if (sclk_fall) begin
          fall_evt = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_req      <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      partial_err <= 1'b0;
      word_cnt    <= '0;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      word_seen   <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_req      <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      partial_err <= 1'b0;

      if (start_evt) begin
        frame_start <= 1'b1;
        word_cnt    <= '0;
        bit_cnt     <= '0;
        rx_shift    <= '0;
        word_seen   <= 1'b0;
        tx_shift    <= tx_data;
        tx_req      <= 1'b1;
      end else if (end_evt) begin
        // Any partial word is dropped; word_cnt is kept for upstream to read.
        frame_end   <= 1'b1;
        partial_err <= (bit_cnt != '0);
        bit_cnt     <= '0;
        rx_shift    <= '0;
        tx_shift    <= '0;
      end else if (rise_evt) begin
        if (bit_cnt == BC_W'(DATA_W - 1)) begin
          rx_data   <= rx_next;
          rx_valid  <= 1'b1;
          bit_cnt   <= '0;
          rx_shift  <= '0;
          word_seen <= 1'b1;
          if (word_cnt != '1) begin
            word_cnt <= word_cnt + CNT_W'(1);
          end
        end else begin
          rx_shift <= rx_next[DATA_W-2:0];
          bit_cnt  <= bit_cnt + BC_W'(1);
        end
      end else if (fall_evt) begin
        if (bit_cnt == '0) begin
          // Word boundary: fetch the next response word, but only after a
          // word has finished so the fall before the first rise is harmless.
          if (word_seen) begin
            tx_shift <= tx_data;
            tx_req   <= 1'b1;
          end
        end else begin
          tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
module tb_spi_slave_if;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        SCLK = 1'b0;
  logic        CS = 1'b1;
  logic        MOSI = 1'b0;
  logic [7:0]  tx_data = 8'h00;

  logic        MISO, rx_valid, tx_req, frame_active, frame_start, frame_end, partial_err;
  logic [7:0]  rx_data;
  logic [15:0] word_cnt;

  logic        MISO2, rx_valid2, tx_req2, frame_active2, frame_start2, frame_end2, partial_err2;
  logic [7:0]  rx_data2;
  logic [1:0]  word_cnt2;

  spi_slave_if #(.SYNC_STAGES(2), .DATA_W(8), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req),
    .frame_active(frame_active), .frame_start(frame_start), .frame_end(frame_end),
    .partial_err(partial_err), .word_cnt(word_cnt)
  );

  // Narrow word counter instance sharing the same pins, for saturation.
  spi_slave_if #(.SYNC_STAGES(2), .DATA_W(8), .CNT_W(2)) dut_sat (
    .CLK(CLK), .RST(RST), .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .tx_data(tx_data), .tx_req(tx_req2),
    .frame_active(frame_active2), .frame_start(frame_start2), .frame_end(frame_end2),
    .partial_err(partial_err2), .word_cnt(word_cnt2)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard queues, filled by the stimulus and drained by the monitors.
  logic [7:0] rx_q[$];
  int         wc_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] up_q[$];
  bit         fe_q[$];

  int txreq_cnt = 0, exp_txreq = 0;
  int fs_cnt = 0, exp_fs = 0;
  int rv2_cnt = 0, exp_rv2 = 0;
  int mon_mode = 0;          // 1: DUT must ignore the current CS-low period
  logic [7:0] preload_val = 8'h00;
  int preload_seq = 0;
  int seen_seq = 0;

  logic [7:0] rxw[8];
  logic [7:0] txw[8];
  logic [7:0] pw;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clks(int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic preload(logic [7:0] v);
    preload_val = v;
    preload_seq++;
    clks(2);
  endtask

  task automatic check_idle(string tag);
    check({tag, "_miso"}, MISO, 0);
    check({tag, "_rx_data"}, rx_data, 0);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_tx_req"}, tx_req, 0);
    check({tag, "_frame_active"}, frame_active, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_frame_end"}, frame_end, 0);
    check({tag, "_partial_err"}, partial_err, 0);
    check({tag, "_word_cnt"}, word_cnt, 0);
  endtask

  // Upstream responder plus output monitor, sampled mid-cycle.
  always @(negedge CLK) begin
    if (preload_seq != seen_seq) begin
      tx_data  = preload_val;
      seen_seq = preload_seq;
    end
    if (!RST) begin
      if (rx_valid) begin
        if (rx_q.size() == 0) begin
          check("rx_valid_unexpected", rx_valid, 0);
        end else begin
          check("rx_data", rx_data, rx_q.pop_front());
          check("word_cnt", word_cnt, wc_q.pop_front());
        end
      end
      if (frame_end) begin
        if (fe_q.size() == 0) check("frame_end_unexpected", frame_end, 0);
        else check("partial_err", partial_err, fe_q.pop_front());
      end else if (partial_err) begin
        check("partial_err_without_frame_end", frame_end, 1);
      end
      if (tx_req) begin
        txreq_cnt++;
        if (up_q.size() != 0) tx_data = up_q.pop_front();
      end
      if (frame_start) fs_cnt++;
      if (rx_valid2) rv2_cnt++;
    end
  end

  // MISO as the SPI master sees it: sampled on each SCLK rise inside a frame.
  logic [7:0] mword = 8'h00;
  int         mbits = 0;
  always @(posedge SCLK or posedge CS or posedge RST) begin
    if (CS || RST) begin
      mbits = 0;
    end else if (mon_mode == 1) begin
      check("miso_ignored_frame", MISO, 0);
    end else begin
      mword = {mword[6:0], MISO};
      mbits++;
      if (mbits == 8) begin
        mbits = 0;
        if (tx_q.size() == 0) check("miso_word_unexpected", tx_q.size(), 1);
        else check("miso_word", mword, tx_q.pop_front());
      end
    end
  end

  // One SPI frame: nw full words from rxw/txw, then pb bits of pw.
  // Normal frames end with CS rising while SCLK is still high after the last
  // rise; race frames raise CS together with the final rise.
  task automatic run_frame(int nw, int pb, bit race);
    int total, complete;
    logic [7:0] cur;
    complete = race ? nw - 1 : nw;
    total    = nw * 8 + pb;
    up_q.delete();
    preload(txw[0]);
    for (int i = 1; i <= nw; i++) up_q.push_back(txw[i]);
    for (int i = 0; i < complete; i++) begin
      rx_q.push_back(rxw[i]);
      wc_q.push_back(i + 1);
      tx_q.push_back(txw[i]);
    end
    fe_q.push_back((pb != 0) || race);
    exp_fs++;
    exp_txreq++;
    exp_rv2 += complete;
    CS = 1'b0;
    clks(8);
    check("frame_active", frame_active, 1);
    for (int b = 0; b < total; b++) begin
      cur  = (b / 8 < nw) ? rxw[b / 8] : pw;
      MOSI = cur[7 - (b % 8)];
      clks(8);
      if (race && b == total - 1) CS = 1'b1;
      SCLK = 1'b1;
      clks(8);
      if (b == total - 1) begin
        if (!race) CS = 1'b1;
        clks(8);
        SCLK = 1'b0;
        clks(8);
      end else begin
        // A fall right after a complete word fetches the next response word.
        if ((b + 1) % 8 == 0) exp_txreq++;
        SCLK = 1'b0;
      end
    end
    clks(4);
    check("frame_active_after", frame_active, 0);
    check("word_cnt_hold", word_cnt, complete);
    check("word_cnt_sat", word_cnt2, (complete > 3) ? 3 : complete);
    check("tx_req_count", txreq_cnt, exp_txreq);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with idle pins.
    RST = 1'b1;
    clks(4);
    RST = 1'b0;
    clks(1);
    check_idle("reset");
    clks(50);
    check("reset_no_frame_start", fs_cnt, 0);

    // Single byte.
    rxw[0] = 8'hA5; txw[0] = 8'h3C; txw[1] = 8'h00;
    run_frame(1, 0, 1'b0);

    // Burst of three with upstream updating tx_data after each tx_req.
    rxw[0] = 8'h01; rxw[1] = 8'h80; rxw[2] = 8'hFF;
    txw[0] = 8'h11; txw[1] = 8'h22; txw[2] = 8'h33; txw[3] = 8'h44;
    run_frame(3, 0, 1'b0);

    // Abort after 5 bits of 0xC3, then a good frame.
    pw = 8'hC3; txw[0] = 8'h96; txw[1] = 8'h00;
    run_frame(0, 5, 1'b0);
    rxw[0] = 8'h5A; txw[0] = 8'hE7; txw[1] = 8'h00;
    run_frame(1, 0, 1'b0);

    // CS rise on the same CLK as the 8th SCLK rise.
    rxw[0] = 8'h6B; txw[0] = 8'h2D; txw[1] = 8'h00;
    run_frame(1, 0, 1'b1);

    // Reset in the middle of a frame, CS held low afterwards.
    up_q.delete();
    preload(8'h77);
    exp_fs++;
    exp_txreq++;
    CS = 1'b0;
    clks(8);
    for (int b = 0; b < 3; b++) begin
      MOSI = b[0];
      clks(8);
      SCLK = 1'b1;
      clks(8);
      SCLK = 1'b0;
    end
    clks(2);
    RST = 1'b1;
    clks(4);
    RST = 1'b0;
    clks(1);
    check_idle("midreset");
    mon_mode = 1;
    for (int b = 0; b < 8; b++) begin
      MOSI = 1'($urandom);
      clks(8);
      SCLK = 1'b1;
      clks(8);
      SCLK = 1'b0;
    end
    clks(8);
    check("midreset_frame_active", frame_active, 0);
    check("midreset_word_cnt", word_cnt, 0);
    CS = 1'b1;
    clks(10);
    mon_mode = 0;
    rxw[0] = 8'hC9; txw[0] = 8'h4E; txw[1] = 8'h00;
    run_frame(1, 0, 1'b0);

    // Five words: the narrow counter sticks at 3.
    for (int i = 0; i < 6; i++) begin
      rxw[i] = 8'($urandom);
      txw[i] = 8'($urandom);
    end
    run_frame(5, 0, 1'b0);

    // Random frames, some ending mid-word.
    for (int f = 0; f < 12; f++) begin
      int nw, pb;
      nw = $urandom_range(1, 4);
      pb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      for (int i = 0; i < 6; i++) begin
        rxw[i] = 8'($urandom);
        txw[i] = 8'($urandom);
      end
      pw = 8'($urandom);
      run_frame(nw, pb, 1'b0);
      clks($urandom_range(4, 20));
    end

    clks(20);
    check("rx_q_drained", rx_q.size(), 0);
    check("tx_q_drained", tx_q.size(), 0);
    check("fe_q_drained", fe_q.size(), 0);
    check("frame_start_count", fs_cnt, exp_fs);
    check("tx_req_total", txreq_cnt, exp_txreq);
    check("sat_rx_valid_count", rv2_cnt, exp_rv2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
